reduction_result_collector: RTL and testbench

//  Downstream consumer of the max-reduction side stream (valid/data/last, no backpressure) produced by the CIRCT top.

---
 rtl/reduction_result_collector.sv | 84 ++++++++
 tb/tb_reduction_result_collector.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reduction_result_collector.sv
// reduction_result_collector: counts beats per reduction packet and queues {beats, value} in a FWFT FIFO with stats.
module reduction_result_collector #(
    parameter int DATA_BITS = 64,
    parameter int DEPTH     = 16,
    parameter int CNT_BITS  = 32
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     clr,
    input  logic                     red_valid,
    input  logic [DATA_BITS-1:0]     red_data,
    input  logic                     red_last,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [DATA_BITS-1:0]     res_data,
    output logic [CNT_BITS-1:0]      res_beats,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [CNT_BITS-1:0]      pkt_cnt,
    output logic [CNT_BITS-1:0]      drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_BITS-1:0] CMAX = '1;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [DATA_BITS-1:0] data_mem_q [DEPTH];
    logic [CNT_BITS-1:0]  beat_mem_q [DEPTH];
    logic [CNT_BITS-1:0]  beat_q, beats_cur, pkt_q, drop_q;
    logic [AW-1:0]        wr_q, rd_q;
    logic [AW:0]          lvl_q, lvl_d;
    logic                 push, pop, accept;

    always_comb begin
        beats_cur = (beat_q == CMAX) ? CMAX : beat_q + 1'b1;
        push      = red_valid & red_last;
        pop       = (lvl_q != '0) & res_ready;
        // a pop in the same cycle frees the slot a full FIFO needs
        accept    = push & ((lvl_q != FULL) | pop);
        lvl_d     = lvl_q + {{AW{1'b0}}, accept} - {{AW{1'b0}}, pop};
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            beat_q <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            lvl_q  <= '0;
            pkt_q  <= '0;
            drop_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_mem_q[i] <= '0;
                beat_mem_q[i] <= '0;
            end
        end else if (clr) begin
            beat_q <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            lvl_q  <= '0;
            pkt_q  <= '0;
            drop_q <= '0;
        end else begin
            if (red_valid)
                beat_q <= red_last ? '0 : beats_cur;
            if (accept) begin
                data_mem_q[wr_q] <= red_data;
                beat_mem_q[wr_q] <= beats_cur;
                wr_q             <= wr_q + 1'b1;
                if (pkt_q != CMAX)
                    pkt_q <= pkt_q + 1'b1;
            end else if (push && drop_q != CMAX) begin
                drop_q <= drop_q + 1'b1;
            end
            if (pop)
                rd_q <= rd_q + 1'b1;
            lvl_q <= lvl_d;
        end
    end

    assign res_valid  = lvl_q != '0;
    assign res_data   = data_mem_q[rd_q];
    assign res_beats  = beat_mem_q[rd_q];
    assign fifo_level = lvl_q;
    assign pkt_cnt    = pkt_q;
    assign drop_cnt   = drop_q;
endmodule

// File: tb/tb_reduction_result_collector.sv
// tb_reduction_result_collector: directed scenarios plus randomized traffic checked against a queue model.
module tb_reduction_result_collector;
    typedef struct {
        logic [31:0] beats;
        logic [63:0] data;
    } ent_t;

    logic        aclk = 1'b0;
    logic        aresetn, clr, red_valid, red_last, res_ready;
    logic [63:0] red_data;
    logic        res_valid;
    logic [63:0] res_data;
    logic [31:0] res_beats, pkt_cnt, drop_cnt;
    logic [4:0]  fifo_level;

    int   n_checks = 0;
    int   n_errors = 0;
    ent_t q[$];
    int   m_acc, m_pkt, m_drop;

    reduction_result_collector #(.DATA_BITS(64), .DEPTH(16), .CNT_BITS(32)) dut (
        .aclk(aclk), .aresetn(aresetn), .clr(clr), .red_valid(red_valid), .red_data(red_data),
        .red_last(red_last), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_beats(res_beats), .fifo_level(fifo_level), .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
    );

    always #5 aclk = ~aclk;

    function automatic void model_reset();
        q.delete();
        m_acc  = 0;
        m_pkt  = 0;
        m_drop = 0;
    endfunction

    // drive one cycle, advance the model on the same inputs, return #1 after the edge
    task automatic cyc(input logic v, input logic [63:0] d, input logic l, input logic r, input logic c);
        ent_t e;
        bit   pop;
        red_valid = v;
        red_data  = d;
        red_last  = l;
        res_ready = r;
        clr       = c;
        if (c) begin
            model_reset();
        end else begin
            pop = q.size() != 0 && r;
            if (pop) void'(q.pop_front());
            if (v && l) begin
                e.beats = 32'(m_acc + 1);
                e.data  = d;
                if (q.size() < 16) begin
                    q.push_back(e);
                    m_pkt++;
                end else begin
                    m_drop++;
                end
            end
            if (v) m_acc = l ? 0 : m_acc + 1;
        end
        @(posedge aclk);
        #1;
        red_valid = 1'b0;
        red_last  = 1'b0;
        res_ready = 1'b0;
        clr       = 1'b0;
    endtask

    task automatic send_pkt(input int nb, input logic [63:0] d, input logic r_last);
        for (int i = 1; i < nb; i++) cyc(1'b1, 64'($urandom), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, d, 1'b1, r_last, 1'b0);
    endtask

    task automatic test_reset();
        aresetn = 1'b0; clr = 1'b0; red_valid = 1'b0; red_last = 1'b0; res_ready = 1'b0; red_data = '0;
        repeat (2) @(posedge aclk);
        #1;
        model_reset();
        n_checks++;
        if ({res_valid, res_data, res_beats, fifo_level, pkt_cnt, drop_cnt} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got valid=%0b data=%h beats=%0d lvl=%0d pkt=%0d drop=%0d, expected all 0",
                     res_valid, res_data, res_beats, fifo_level, pkt_cnt, drop_cnt);
        end
        aresetn = 1'b1;
    endtask

    task automatic test_three_beats();
        send_pkt(3, 64'h2A, 1'b0);
        n_checks++;
        if (res_valid !== 1'b1 || res_data !== 64'h2A || res_beats !== 32'd3 || pkt_cnt !== 32'd1 || fifo_level !== 5'd1) begin
            n_errors++;
            $display("FAIL three_beats: got valid=%0b data=%h beats=%0d pkt=%0d lvl=%0d, expected 1 2a 3 1 1",
                     res_valid, res_data, res_beats, pkt_cnt, fifo_level);
        end
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (fifo_level !== 5'd0) begin
            n_errors++;
            $display("FAIL three_beats_pop: got lvl=%0d, expected 0", fifo_level);
        end
    endtask

    task automatic test_single_beat();
        cyc(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (res_valid !== 1'b1 || res_data !== 64'hFFFF_FFFF_FFFF_FFFF || res_beats !== 32'd1 || fifo_level !== 5'd1) begin
            n_errors++;
            $display("FAIL single_beat: got valid=%0b data=%h beats=%0d lvl=%0d, expected 1 ffffffffffffffff 1 1",
                     res_valid, res_data, res_beats, fifo_level);
        end
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (res_valid !== 1'b0 || fifo_level !== 5'd0) begin
            n_errors++;
            $display("FAIL single_beat_pop: got valid=%0b lvl=%0d, expected 0 0", res_valid, fifo_level);
        end
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (res_valid !== 1'b0 || fifo_level !== 5'd0) begin
            n_errors++;
            $display("FAIL pop_when_empty: got valid=%0b lvl=%0d, expected 0 0", res_valid, fifo_level);
        end
    endtask

    task automatic test_full_drop();
        logic [63:0] d0;
        int          b0;
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        b0 = int'($urandom_range(1, 4));
        d0 = {$urandom, $urandom};
        send_pkt(b0, d0, 1'b0);
        for (int i = 1; i < 16; i++) send_pkt(int'($urandom_range(1, 4)), {$urandom, $urandom}, 1'b0);
        send_pkt(2, 64'h1717, 1'b0);
        repeat (3) cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (fifo_level !== 5'd16 || drop_cnt !== 32'd1 || pkt_cnt !== 32'd16) begin
            n_errors++;
            $display("FAIL full_drop_counts: got lvl=%0d drop=%0d pkt=%0d, expected 16 1 16", fifo_level, drop_cnt, pkt_cnt);
        end
        n_checks++;
        if (res_valid !== 1'b1 || res_data !== d0 || res_beats !== 32'(b0)) begin
            n_errors++;
            $display("FAIL full_drop_head: got valid=%0b data=%h beats=%0d, expected 1 %h %0d", res_valid, res_data, res_beats, d0, b0);
        end
    endtask

    task automatic test_full_push_pop();
        logic [63:0] d17;
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) send_pkt(int'($urandom_range(1, 3)), {$urandom, $urandom}, 1'b0);
        d17 = {$urandom, $urandom};
        send_pkt(3, d17, 1'b1);
        n_checks++;
        if (fifo_level !== 5'd16 || drop_cnt !== 32'd0 || pkt_cnt !== 32'd17) begin
            n_errors++;
            $display("FAIL full_push_pop_counts: got lvl=%0d drop=%0d pkt=%0d, expected 16 0 17", fifo_level, drop_cnt, pkt_cnt);
        end
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (res_valid !== 1'b1 || res_data !== q[0].data || res_beats !== q[0].beats) begin
                n_errors++;
                $display("FAIL drain_order[%0d]: got valid=%0b data=%h beats=%0d, expected 1 %h %0d",
                         i, res_valid, res_data, res_beats, q[0].data, q[0].beats);
            end
            if (i == 15) begin
                n_checks++;
                if (res_data !== d17 || res_beats !== 32'd3) begin
                    n_errors++;
                    $display("FAIL last_out: got data=%h beats=%0d, expected %h 3", res_data, res_beats, d17);
                end
            end
            cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
        end
        n_checks++;
        if (res_valid !== 1'b0 || fifo_level !== 5'd0) begin
            n_errors++;
            $display("FAIL drain_empty: got valid=%0b lvl=%0d, expected 0 0", res_valid, fifo_level);
        end
    endtask

    task automatic test_reset_mid_packet();
        send_pkt(2, 64'h5, 1'b0);
        cyc(1'b1, 64'h6, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 64'h7, 1'b0, 1'b0, 1'b0);
        aresetn = 1'b0;
        #2;
        model_reset();
        n_checks++;
        if (fifo_level !== 5'd0 || pkt_cnt !== 32'd0 || res_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL async_reset: got lvl=%0d pkt=%0d valid=%0b, expected 0 0 0", fifo_level, pkt_cnt, res_valid);
        end
        aresetn = 1'b1;
        send_pkt(4, 64'h44, 1'b0);
        n_checks++;
        if (res_beats !== 32'd4 || res_data !== 64'h44 || pkt_cnt !== 32'd1 || drop_cnt !== 32'd0 || fifo_level !== 5'd1) begin
            n_errors++;
            $display("FAIL reset_mid_packet: got beats=%0d data=%h pkt=%0d drop=%0d lvl=%0d, expected 4 44 1 0 1",
                     res_beats, res_data, pkt_cnt, drop_cnt, fifo_level);
        end
    endtask

    task automatic test_clr();
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) send_pkt(2, 64'(i), 1'b0);
        cyc(1'b1, 64'h9, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 64'hA, 1'b1, 1'b1, 1'b1);
        n_checks++;
        if (fifo_level !== 5'd0 || pkt_cnt !== 32'd0 || drop_cnt !== 32'd0 || res_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL clr: got lvl=%0d pkt=%0d drop=%0d valid=%0b, expected 0 0 0 0", fifo_level, pkt_cnt, drop_cnt, res_valid);
        end
        cyc(1'b1, 64'hB, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (res_beats !== 32'd1 || pkt_cnt !== 32'd1) begin
            n_errors++;
            $display("FAIL clr_accumulator: got beats=%0d pkt=%0d, expected 1 1", res_beats, pkt_cnt);
        end
    endtask

    task automatic test_random();
        int rdy_pct;
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            rdy_pct = (i / 500) % 2 == 0 ? 15 : 70;
            cyc($urandom_range(0, 3) != 0, {$urandom, $urandom}, $urandom_range(0, 2) == 0,
                $urandom_range(0, 99) < rdy_pct, $urandom_range(0, 299) == 0);
            n_checks++;
            if (fifo_level !== 5'(q.size()) || res_valid !== (q.size() != 0) || pkt_cnt !== 32'(m_pkt) || drop_cnt !== 32'(m_drop)) begin
                n_errors++;
                $display("FAIL random_state[%0d]: got lvl=%0d valid=%0b pkt=%0d drop=%0d, expected %0d %0b %0d %0d",
                         i, fifo_level, res_valid, pkt_cnt, drop_cnt, q.size(), q.size() != 0, m_pkt, m_drop);
            end
            if (q.size() != 0) begin
                n_checks++;
                if (res_data !== q[0].data || res_beats !== q[0].beats) begin
                    n_errors++;
                    $display("FAIL random_head[%0d]: got data=%h beats=%0d, expected %h %0d",
                             i, res_data, res_beats, q[0].data, q[0].beats);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_three_beats();
        test_single_beat();
        test_full_drop();
        test_full_push_pop();
        test_reset_mid_packet();
        test_clr();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
